aabb_bound_builder: RTL and testbench

Sequential AABB producer: accepts a stream of Fixed3 points grouped into primitives or BVH leaves, folds each group into a per-axis min/max bound, then emits one `AABB` per group. The bound is padded by a guard epsilon and translated by a per-group offset. It is the writer side of the box data that the ray/box hit units consume, and sits between geometry fetch and BVH node storage.

---
 rtl/aabb_bound_builder.sv | 192 +++++++++++++++++++
 tb/tb_aabb_bound_builder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aabb_bound_builder.sv
// Folds a stream of signed Fixed3 points into one padded, offset AABB per group.
// Latency: last point accepted in cycle N, box valid in cycle N+2; groups never overlap.
// Backpressure: in_ready low during FIN/OUT; output held stable until out_ready.
// Packing: Fixed3 = {x, y, z} with x in the MSBs; AABB = {Min, Max} with Min in the MSBs.
module aabb_bound_builder #(
  parameter int PAD         = 1,
  parameter int COUNT_WIDTH = 8,
  parameter int FIXED_WIDTH = 16,
  parameter int PI_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*FIXED_WIDTH-1:0] in_point,
  input  logic                     in_last,
  input  logic [PI_WIDTH-1:0]      in_pi,
  input  logic [3*FIXED_WIDTH-1:0] offset,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6*FIXED_WIDTH-1:0] out_aabb,
  output logic [PI_WIDTH-1:0]      out_pi,
  output logic [COUNT_WIDTH-1:0]   out_count
);

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;
  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } fixed3_t;
  typedef struct packed {
    fixed3_t min_pt;
    fixed3_t max_pt;
  } aabb_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FIN, S_OUT} state_t;

  localparam int W2 = FIXED_WIDTH + 2;
  localparam logic signed [W2-1:0] FMAX_W = W2'((longint'(1) <<< (FIXED_WIDTH - 1)) - 1);
  localparam logic signed [W2-1:0] FMIN_W = ~FMAX_W;
  localparam logic signed [W2-1:0] PAD_W  = W2'(PAD);
  localparam logic [PI_WIDTH-1:0]  NULL_PRIMITIVE_INDEX = '1;

  // Ties keep the existing accumulator value (argument a).
  function automatic fixed_t f_min(fixed_t a, fixed_t b);
    return (b < a) ? b : a;
  endfunction

  function automatic fixed_t f_max(fixed_t a, fixed_t b);
    return (b > a) ? b : a;
  endfunction

  function automatic fixed3_t min3(fixed3_t a, fixed3_t b);
    fixed3_t r;
    r.x = f_min(a.x, b.x);
    r.y = f_min(a.y, b.y);
    r.z = f_min(a.z, b.z);
    return r;
  endfunction

  function automatic fixed3_t max3(fixed3_t a, fixed3_t b);
    fixed3_t r;
    r.x = f_max(a.x, b.x);
    r.y = f_max(a.y, b.y);
    r.z = f_max(a.z, b.z);
    return r;
  endfunction

  // Two guard bits hold any sum of two Fixed values plus the pad before clamping.
  function automatic fixed_t sat_add(fixed_t a, fixed_t o, logic signed [W2-1:0] p);
    logic signed [W2-1:0] s;
    fixed_t r;
    s = W2'(a) + W2'(o) + p;
    if (s > FMAX_W)      r = FMAX_W[FIXED_WIDTH-1:0];
    else if (s < FMIN_W) r = FMIN_W[FIXED_WIDTH-1:0];
    else                 r = s[FIXED_WIDTH-1:0];
    return r;
  endfunction

  function automatic fixed3_t sat_add3(fixed3_t a, fixed3_t o, logic signed [W2-1:0] p);
    fixed3_t r;
    r.x = sat_add(a.x, o.x, p);
    r.y = sat_add(a.y, o.y, p);
    r.z = sat_add(a.z, o.z, p);
    return r;
  endfunction

  state_t                 state_q, state_d;
  fixed3_t                acc_min_q, acc_min_d;
  fixed3_t                acc_max_q, acc_max_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PI_WIDTH-1:0]    pi_q, pi_d;
  fixed3_t                off_q, off_d;
  aabb_t                  out_aabb_q, out_aabb_d;
  logic [PI_WIDTH-1:0]    out_pi_q, out_pi_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;

  fixed3_t pt;
  fixed3_t off_in;
  logic    in_fire;
  logic    out_fire;

  assign pt       = in_point;
  assign off_in   = offset;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State and datapath registers; reset discards any open group.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_min_q   <= '0;
      acc_max_q   <= '0;
      cnt_q       <= '0;
      pi_q        <= '0;
      off_q       <= '0;
      out_aabb_q  <= '0;
      out_pi_q    <= NULL_PRIMITIVE_INDEX;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      cnt_q       <= cnt_d;
      pi_q        <= pi_d;
      off_q       <= off_d;
      out_aabb_q  <= out_aabb_d;
      out_pi_q    <= out_pi_d;
      out_count_q <= out_count_d;
    end
  end

  // Next-state: accumulate until in_last, one finalise cycle, then hold output.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_ACCUM: if (in_fire) state_d = in_last ? S_FIN : S_ACCUM;
      S_FIN:           state_d = S_OUT;
      S_OUT:           if (out_fire) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Datapath: open/fold the group, then pad, offset and clamp into the output registers.
  always_comb begin
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    cnt_d       = cnt_q;
    pi_d        = pi_q;
    off_d       = off_q;
    out_aabb_d  = out_aabb_q;
    out_pi_d    = out_pi_q;
    out_count_d = out_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          acc_min_d = pt;
          acc_max_d = pt;
          cnt_d     = COUNT_WIDTH'(1);
          pi_d      = in_pi;
          off_d     = off_in;
        end
      end
      S_ACCUM: begin
        if (in_fire) begin
          acc_min_d = min3(acc_min_q, pt);
          acc_max_d = max3(acc_max_q, pt);
          cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        out_aabb_d.min_pt = sat_add3(acc_min_q, off_q, -PAD_W);
        out_aabb_d.max_pt = sat_add3(acc_max_q, off_q, PAD_W);
        out_pi_d          = pi_q;
        out_count_d       = cnt_q;
      end
      default: ;
    endcase
  end

  // Handshake outputs: accept only while a group can be opened or extended.
  always_comb begin
    in_ready  = !reset && ((state_q == S_IDLE) || (state_q == S_ACCUM));
    out_valid = (state_q == S_OUT);
  end

  assign out_aabb  = out_aabb_q;
  assign out_pi    = out_pi_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_aabb_bound_builder.sv
// Scoreboard bench: two instances (PAD=1/COUNT_WIDTH=8 and PAD=0/COUNT_WIDTH=2) share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected boxes are hand-computed per group and queued per instance.
module tb_aabb_bound_builder;

  typedef logic signed [15:0] fx_t;
  typedef struct packed { fx_t x; fx_t y; fx_t z; } f3_t;
  typedef struct packed { f3_t mn; f3_t mx; } box_t;
  typedef struct { box_t box; logic [15:0] pi; int cnt; } exp_t;

  localparam logic [15:0] NULLPI = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  f3_t         in_point = '0;
  f3_t         offset = '0;
  logic [15:0] in_pi = '0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [95:0] out_aabb_a, out_aabb_b;
  logic [15:0] out_pi_a, out_pi_b;
  logic [7:0]  out_count_a;
  logic [1:0]  out_count_b;

  int checks = 0;
  int failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  aabb_bound_builder #(.PAD(1), .COUNT_WIDTH(8), .FIXED_WIDTH(16), .PI_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_point(in_point), .in_last(in_last), .in_pi(in_pi), .offset(offset),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_aabb(out_aabb_a),
    .out_pi(out_pi_a), .out_count(out_count_a)
  );

  aabb_bound_builder #(.PAD(0), .COUNT_WIDTH(2), .FIXED_WIDTH(16), .PI_WIDTH(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_point(in_point), .in_last(in_last), .in_pi(in_pi), .offset(offset),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_aabb(out_aabb_b),
    .out_pi(out_pi_b), .out_count(out_count_b)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic f3_t p3(int x, int y, int z);
    f3_t r;
    r.x = fx_t'(x);
    r.y = fx_t'(y);
    r.z = fx_t'(z);
    return r;
  endfunction

  function automatic box_t bx(f3_t mn, f3_t mx);
    box_t r;
    r.mn = mn;
    r.mx = mx;
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(box_t ba, box_t bb, logic [15:0] pi, int ca, int cb);
    exp_t e;
    e.box = ba; e.pi = pi; e.cnt = ca;
    q_a.push_back(e);
    e.box = bb; e.cnt = cb;
    q_b.push_back(e);
  endtask

  // Presents one point and holds it until accepted; returns 1 unit after the accepting edge.
  task automatic send(f3_t p, f3_t off, logic [15:0] pi, logic last);
    bit ok;
    bit done;
    done = 0;
    in_valid = 1'b1; in_point = p; offset = off; in_pi = pi; in_last = last;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      ok = in_ready_a;
      tick();
      if (ok) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
    in_valid = 1'b0; in_last = 1'b0; in_point = p3(999, -999, 999); in_pi = 16'h5A5A;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d/%0d pending required=0", q_a.size(), q_b.size());
    end
  endtask

  // Monitors: pop and compare whenever an output handshake is about to occur.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a && out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_out", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_box", out_aabb_a, e.box);
        chk("a_pi", out_pi_a, e.pi);
        chk("a_count", out_count_a, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid_b && out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_out", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_box", out_aabb_b, e.box);
        chk("b_pi", out_pi_b, e.pi);
        chk("b_count", out_count_b, e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_out_valid_b", out_valid_b, 0);
    chk("rst_in_ready_a", in_ready_a, 0);
    chk("rst_count_a", out_count_a, 0);
    chk("rst_pi_a", out_pi_a, NULLPI);
    chk("rst_pi_b", out_pi_b, NULLPI);
    chk("rst_aabb_a", out_aabb_a, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_a, 1);
    tick();

    // Single point with latency check
    push(bx(p3(2, -3, 4), p3(4, -1, 6)), bx(p3(3, -2, 5), p3(3, -2, 5)), 16'h0011, 1, 1);
    send(p3(3, -2, 5), p3(0, 0, 0), 16'h0011, 1'b1);
    @(negedge clk);
    chk("lat_fin_no_valid", out_valid_a, 0);
    chk("lat_fin_in_ready", in_ready_a, 0);
    tick();
    @(negedge clk);
    chk("lat_out_valid", out_valid_a, 1);
    drain();

    // Three points; pi/offset taken from the first point only
    push(bx(p3(6, -6, -8), p3(13, 5, 7)), bx(p3(7, -5, -7), p3(12, 4, 6)), 16'h0022, 3, 3);
    send(p3(1, 4, -7), p3(10, 0, 0), 16'h0022, 1'b0);
    send(p3(-3, 2, 0), p3(50, 50, 50), 16'h0099, 1'b0);
    send(p3(2, -5, 6), p3(-9, -9, -9), 16'h0098, 1'b1);
    drain();

    // Clamp at Fixed max and Fixed min on x
    push(bx(p3(32766, -1, -1), p3(32767, 1, 1)), bx(p3(32767, 0, 0), p3(32767, 0, 0)), 16'h0033, 1, 1);
    send(p3(32767, 0, 0), p3(0, 0, 0), 16'h0033, 1'b1);
    drain();
    push(bx(p3(-32768, -1, -1), p3(-32767, 1, 1)), bx(p3(-32768, 0, 0), p3(-32768, 0, 0)), 16'h0044, 1, 1);
    send(p3(-32768, 0, 0), p3(0, 0, 0), 16'h0044, 1'b1);
    drain();

    // Backpressure: output held 5 cycles while a new point waits
    out_ready = 1'b0;
    push(bx(p3(3, 6, 1), p3(5, 8, 3)), bx(p3(4, 7, 2), p3(4, 7, 2)), 16'h0055, 1, 1);
    send(p3(5, 5, 5), p3(-1, 2, -3), 16'h0055, 1'b1);
    tick();
    in_valid = 1'b1; in_point = p3(7, 8, 9); offset = p3(0, 0, 0); in_pi = 16'h0066; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_aabb_stable", out_aabb_a, bx(p3(3, 6, 1), p3(5, 8, 3)));
      tick();
    end
    push(bx(p3(6, 7, 8), p3(8, 9, 10)), bx(p3(7, 8, 9), p3(7, 8, 9)), 16'h0066, 1, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready_a, 0);
    tick();
    @(negedge clk);
    chk("bp_after_hs_in_ready", in_ready_a, 1);
    chk("bp_after_hs_out_valid", out_valid_a, 0);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // Reset in the middle of a 4-point group
    send(p3(100, 100, 100), p3(0, 0, 0), 16'h0070, 1'b0);
    send(p3(-100, -100, -100), p3(0, 0, 0), 16'h0071, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready_a, 0);
    tick();
    @(negedge clk);
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_count", out_count_a, 0);
    chk("midrst_pi", out_pi_a, NULLPI);
    chk("midrst_aabb", out_aabb_a, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready_a, 1);
    tick();
    push(bx(p3(-5, 0, 1), p3(-3, 2, 3)), bx(p3(-4, 1, 2), p3(-4, 1, 2)), 16'h0077, 1, 1);
    send(p3(-4, 1, 2), p3(0, 0, 0), 16'h0077, 1'b1);
    drain();

    // Six points: count saturates at 3 in the COUNT_WIDTH=2 instance
    push(bx(p3(-4, -7, -5), p3(5, 4, 6)), bx(p3(-3, -6, -4), p3(4, 3, 5)), 16'h0088, 6, 3);
    send(p3(1, 1, 1), p3(0, 0, 0), 16'h0088, 1'b0);
    send(p3(2, -2, 0), p3(0, 0, 0), 16'h0001, 1'b0);
    send(p3(-3, 3, 0), p3(0, 0, 0), 16'h0001, 1'b0);
    send(p3(0, 0, -4), p3(0, 0, 0), 16'h0001, 1'b0);
    send(p3(4, 0, 5), p3(0, 0, 0), 16'h0001, 1'b0);
    send(p3(0, -6, 0), p3(0, 0, 0), 16'h0001, 1'b1);
    drain();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
